imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Arbitrates single-port instruction/coefficient memory `imem` between two requesters: the host loader, which writes the image, and the FIR core fetch unit, which reads it. Grants one access per cycle. Drives the `imem` macro pins (`CEN`, `WEN`, `A`, `D`) from registers and returns read data with a fixed latency. Sits directly in front of `imem` in the FIR top level.

## Interface
- `ADDR_W`, default 14: `imem` address width (16384 words).
- `DATA_W`, default 16: `imem` word width.

- `CLK` in 1: single clock, rising edge.
- `RSTN` in 1: synchronous, active-low reset.
- `wr_req` in 1: loader write request.
- `wr_addr` in ADDR_W: loader write address.
- `wr_data` in DATA_W: loader write data.
- `wr_lock` in 1: loader burst lock; while high, only the loader is granted.
- `wr_gnt` out 1: loader request accepted this cycle.
- `rd_req` in 1: fetch read request.
- `rd_addr` in ADDR_W: fetch read address.
- `rd_gnt` out 1: fetch request accepted this cycle.
- `rd_valid` out 1: `rd_data` valid this cycle.
- `rd_data` out DATA_W: read data, equal to `mem_q`.
- `mem_cen` out 1: to `imem` CEN, active-low.
- `mem_wen` out 1: to `imem` WEN; 0 means write, 1 means read.
- `mem_a` out ADDR_W: to `imem` A.
- `mem_d` out DATA_W: to `imem` D.
- `mem_q` in DATA_W: from `imem` Q.

## Operation
- Transfer rule: a transfer occurs at the rising edge where `req && gnt`. Grants are combinational from the current `req`, the lock state and the arbitration state.
- At most one of `wr_gnt` or `rd_gnt` is high in any cycle. Neither grant is high while `RSTN` is low.
- State machine ARB / LOCKED:
  - ARB → LOCKED when `wr_lock` is 1 at an edge.
  - LOCKED → ARB when `wr_lock` is 0 at an edge.
  - In LOCKED: `wr_gnt = wr_req` and `rd_gnt = 0`.
  - In ARB with a single request: that request is granted.
  - In ARB with both requests: resolved per Configuration.
- On an accepted transfer, at the same edge:
  - `mem_cen` ← 0.
  - `mem_wen` ← 0 for a write, 1 for a read.
  - `mem_a` ← the granted requester's address.
  - `mem_d` ← `wr_data` for a write; holds its previous value for a read.
- With no transfer, `mem_cen` ← 1 and `mem_a`, `mem_d`, `mem_wen` hold their values.
- Read return: a 2-stage pending pipeline.
  - `rd_valid` is high exactly 2 cycles after the accepting edge, for one cycle.
  - `rd_data` passes `mem_q` through unregistered.
- Back-to-back reads give one `rd_valid` per cycle, in request order.
- A read already pending when `wr_lock` rises still completes.
- Reset values: `mem_cen` = 1, `mem_wen` = 1, `mem_a` = 0, `mem_d` = 0, `rd_valid` = 0, state = ARB, round-robin pointer = read-favoured.
- Reset mid-operation: all pending reads are discarded and no `rd_valid` is issued for them.
- Addresses pass through unmodified over the full range 0..0x3FFF. There is no wrap or bounds check.

## Timing
- Request to memory pins: 1 cycle, registered.
- Read request to `rd_valid`: 2 cycles.
- Throughput: 1 access per cycle. No bubble is inserted on a switch between write and read.
- A write followed by a read of the same address in the next cycle returns the new data, because `imem` orders accesses.
- `wr_lock` takes effect on the cycle after it is sampled. Grants in the sampling cycle follow the ARB rules.

## Configuration
- `IMEM_ARB_RR_EN`
  - Defined: both-request ties in ARB alternate round-robin. A 1-bit pointer toggles to favour the requester not granted last, and is updated on every contended grant.
  - Undefined: fixed priority, fetch (read) always wins ties. The loader can starve except through `wr_lock`.

## Structure
- Shared package `imem_pkg`:
  - `IMEM_ADDR_W` = 14 and `IMEM_DATA_W` = 16.
  - Enum `arb_state_t` {ARB, LOCKED}.
  - Requester index constants `REQ_RD` = 0 and `REQ_WR` = 1.
- One sub-module, `rr_arb2`: 2-input arbiter, combinational grant plus pointer register. It is compiled for both the round-robin and fixed-priority modes.

## Test plan
- Write 350 to address 1, then read address 1: `mem_cen` low for 2 cycles, `mem_wen` 0 then 1, `rd_valid` 2 cycles after the read grant, `rd_data` = 350.
- Fill all 16384 addresses with a file pattern, then read them back-to-back: one `rd_valid` per cycle, zero mismatches, address 0x3FFF correct.
- `wr_req` and `rd_req` held high together for 6 cycles, with `IMEM_ARB_RR_EN` defined: grants alternate RD, WR, RD, WR, RD, WR. Without the macro: 6 RD grants and 0 WR grants.
- `wr_lock` high with both requests present: `rd_gnt` stays 0 from the cycle after sampling. A read accepted just before the lock still returns its `rd_valid`.
- `RSTN` low 1 cycle after a read is granted: no `rd_valid` is issued, `mem_cen` = 1, `mem_a` = 0, state = ARB.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the imem arbiter: widths, arbitration state and
// requester indices used by the arbiter and its 2-input grant sub-module.
package imem_pkg;

  localparam int IMEM_ADDR_W = 14;
  localparam int IMEM_DATA_W = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Requester indices into the 2-bit request/grant vectors
  localparam int REQ_RD = 0;
  localparam int REQ_WR = 1;

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// rr_arb2: 2-input arbiter with combinational grant and a 1-bit favour
// pointer. Optional feature macro: IMEM_ARB_RR_EN. When defined, contended
// grants alternate between the two requesters; when undefined, the pointer
// never leaves its reset value, so the read requester wins every tie.
module rr_arb2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef IMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // Index of the requester that wins a tie
  logic fav_reg;
  logic contended;

  assign contended = en & req[0] & req[1];

  // A requester wins if it asks and either its rival is idle or it is favoured
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = en & req[gi] & (~req[1-gi] | (fav_reg == 1'(gi)));
    end
  endgenerate

  // After a tie, favour the requester that just lost
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fav_reg <= 1'(REQ_RD);
    end else if (contended && RR_EN) begin
      fav_reg <= ~fav_reg;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port imem between the host loader (writes)
// and the FIR fetch unit (reads). One access per cycle, registered macro pins,
// read data returned two cycles after the accepting edge.
// Optional feature macro: IMEM_ARB_RR_EN (round-robin tie breaking in rr_arb2).
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_lock,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  arb_state_t        state_reg;
  logic [1:0]        arb_req;
  logic [1:0]        arb_gnt;
  logic              arb_en;
  logic              mem_cen_reg;
  logic              mem_wen_reg;
  logic [ADDR_W-1:0] mem_a_reg;
  logic [DATA_W-1:0] mem_d_reg;
  logic              pend_reg;
  logic              rd_valid_reg;

  assign arb_req[REQ_RD] = rd_req;
  assign arb_req[REQ_WR] = wr_req;
  assign arb_en          = RSTN && (state_reg == ARB);

  rr_arb2 u_rr_arb2 (
    .clk  (CLK),
    .rstn (RSTN),
    .en   (arb_en),
    .req  (arb_req),
    .gnt  (arb_gnt)
  );

  // Grants: loader only while locked, otherwise the arbiter decides
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (RSTN) begin
      if (state_reg == LOCKED) begin
        wr_gnt = wr_req;
      end else begin
        wr_gnt = arb_gnt[REQ_WR];
        rd_gnt = arb_gnt[REQ_RD];
      end
    end
  end

  // Lock state follows the sampled wr_lock, so it acts one cycle later
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_reg <= ARB;
    end else begin
      case (state_reg)
        ARB:     if (wr_lock)  state_reg <= LOCKED;
        LOCKED:  if (!wr_lock) state_reg <= ARB;
        default: state_reg <= ARB;
      endcase
    end
  end

  // Macro pins: enable only on an accepted transfer, address/data hold otherwise
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      mem_cen_reg <= 1'b1;
      mem_wen_reg <= 1'b1;
      mem_a_reg   <= '0;
      mem_d_reg   <= '0;
    end else if (wr_gnt) begin
      mem_cen_reg <= 1'b0;
      mem_wen_reg <= 1'b0;
      mem_a_reg   <= wr_addr;
      mem_d_reg   <= wr_data;
    end else if (rd_gnt) begin
      mem_cen_reg <= 1'b0;
      mem_wen_reg <= 1'b1;
      mem_a_reg   <= rd_addr;
    end else begin
      mem_cen_reg <= 1'b1;
    end
  end

  // Read return: pin stage then macro stage; reset drops anything in flight
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pend_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      pend_reg     <= rd_gnt;
      rd_valid_reg <= pend_reg;
    end
  end

  assign mem_cen  = mem_cen_reg;
  assign mem_wen  = mem_wen_reg;
  assign mem_a    = mem_a_reg;
  assign mem_d    = mem_d_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = mem_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: synchronous imem model on the macro pins, a
// transaction-level reference (shadow memory + queue of due reads) checked on
// every falling edge, directed scenarios with literal expectations, and a
// randomized phase.
module tb_imem_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int DEPTH = 16384;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          wr_req, wr_lock, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt, rd_gnt, rd_valid;
  logic [DW-1:0] rd_data;
  logic          mem_cen, mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d, mem_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lock(wr_lock),
    .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d),
    .mem_q(mem_q)
  );

  always #5 CLK = ~CLK;

  // imem macro: synchronous single port, registered Q
  logic [DW-1:0] imem [0:DEPTH-1];
  logic [DW-1:0] q_reg;
  assign mem_q = q_reg;

  initial begin
    for (int i = 0; i < DEPTH; i++) imem[i] <= '0;
  end

  always @(posedge CLK) begin
    if (mem_cen === 1'b0) begin
      if (mem_wen === 1'b0) imem[mem_a] <= mem_d;
      else                  q_reg <= imem[mem_a];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the spec says happens, as transactions
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rq[$];
  logic [DW-1:0] shadow [0:DEPTH-1];
  bit            m_ready = 1'b0;
  bit            m_locked = 1'b0;
  bit            m_fav_wr = 1'b0;
  logic          m_cen = 1'b1, m_wen = 1'b1;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
  end

  always @(negedge CLK) begin
    logic e_wr, e_rd;
    bit   exp_v;
    e_wr = 1'b0;
    e_rd = 1'b0;
    if (RSTN === 1'b1) begin
      if (m_locked) begin
        e_wr = wr_req;
      end else if (wr_req && rd_req) begin
`ifdef IMEM_ARB_RR_EN
        e_wr = m_fav_wr;
        e_rd = !m_fav_wr;
`else
        e_rd = 1'b1;
`endif
      end else begin
        e_wr = wr_req;
        e_rd = rd_req;
      end
    end
    if (m_ready) begin
      chk("wr_gnt", wr_gnt, e_wr);
      chk("rd_gnt", rd_gnt, e_rd);
      chk("mem_cen", mem_cen, m_cen);
      chk("mem_wen", mem_wen, m_wen);
      chk("mem_a", mem_a, m_a);
      chk("mem_d", mem_d, m_d);
      exp_v = (rq.size() > 0) && (rq[0].due == cyc);
      chk("rd_valid", rd_valid, exp_v);
      if (exp_v) begin
        chk("rd_data", rd_data, rq[0].data);
        void'(rq.pop_front());
      end
    end
    if (RSTN !== 1'b1) begin
      m_locked = 1'b0;
      m_fav_wr = 1'b0;
      m_cen = 1'b1; m_wen = 1'b1; m_a = '0; m_d = '0;
      rq.delete();
      m_ready = 1'b1;
    end else begin
      if (!m_locked && wr_req && rd_req) m_fav_wr = e_rd;
      m_locked = wr_lock;
      if (e_wr) begin
        m_cen = 1'b0; m_wen = 1'b0; m_a = wr_addr; m_d = wr_data;
        shadow[wr_addr] = wr_data;
      end else if (e_rd) begin
        m_cen = 1'b0; m_wen = 1'b1; m_a = rd_addr;
        rq.push_back('{due: cyc + 2, data: shadow[rd_addr]});
      end else begin
        m_cen = 1'b1;
      end
    end
    cyc++;
  end

  // rd_valid counter for the bulk readback
  bit count_en = 1'b0;
  int vcnt = 0;
  always @(negedge CLK) if (count_en && rd_valid === 1'b1) vcnt++;

  task automatic go();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wr_req = 0; rd_req = 0; wr_lock = 0;
  endtask

  task automatic do_reset();
    RSTN = 0; idle(); go(); RSTN = 1;
  endtask

  logic [1:0] g_hist [6];
  int         rd_cnt;

  initial begin
    RSTN = 0; idle();
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    go(); go(); RSTN = 1;

    // Reset state of the pins
    @(negedge CLK);
    chk("rst_cen", mem_cen, 1); chk("rst_wen", mem_wen, 1);
    chk("rst_a", mem_a, 0);     chk("rst_d", mem_d, 0);
    chk("rst_valid", rd_valid, 0);
    $display("txn reset done");
    go();

    // Write 350 to address 1, then read it back
    wr_req = 1; wr_addr = 14'd1; wr_data = 16'd350;
    @(negedge CLK); chk("t1_wgnt", wr_gnt, 1);
    go();
    wr_req = 0; rd_req = 1; rd_addr = 14'd1;
    @(negedge CLK); chk("t1_rgnt", rd_gnt, 1); chk("t1_cen0", mem_cen, 0); chk("t1_wen0", mem_wen, 0);
    go();
    rd_req = 0;
    @(negedge CLK); chk("t1_cen1", mem_cen, 0); chk("t1_wen1", mem_wen, 1); chk("t1_v_early", rd_valid, 0);
    go();
    @(negedge CLK); chk("t1_valid", rd_valid, 1); chk("t1_data", rd_data, 350); chk("t1_cen_idle", mem_cen, 1);
    $display("txn write a=1 d=350 / read a=1 -> %0d", rd_data);
    go();

    // Both requests held for 6 cycles from a fresh pointer
    do_reset();
    wr_req = 1; rd_req = 1; wr_addr = 14'h0A0; rd_addr = 14'h0B0; wr_data = 16'hBEEF;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); g_hist[i] = {wr_gnt, rd_gnt};
      go();
    end
    idle();
    rd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (g_hist[i] == 2'b01) rd_cnt++;
`ifdef IMEM_ARB_RR_EN
      chk("tie_seq", g_hist[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      chk("tie_seq", g_hist[i], 2'b01);
`endif
    end
`ifdef IMEM_ARB_RR_EN
    chk("tie_rd_cnt", rd_cnt, 3);
`else
    chk("tie_rd_cnt", rd_cnt, 6);
`endif
    $display("txn contention 6 cycles: rd grants %0d", rd_cnt);
    go(); go();

    // Lock with both requests; reads accepted before it still return
    rd_req = 1; rd_addr = 14'h0A0;
    @(negedge CLK); chk("lk_pre_rgnt", rd_gnt, 1);
    go();
    wr_req = 1; wr_lock = 1; wr_addr = 14'h0C0; wr_data = 16'h1111;
    @(negedge CLK); chk("lk_sample_rgnt", rd_gnt, 1);
    go();
    @(negedge CLK); chk("lk_rgnt0", rd_gnt, 0); chk("lk_wgnt1", wr_gnt, 1); chk("lk_valid_a", rd_valid, 1);
    go();
    @(negedge CLK); chk("lk_rgnt1", rd_gnt, 0); chk("lk_valid_b", rd_valid, 1);
    go();
    wr_lock = 0;
    @(negedge CLK); chk("lk_release_rgnt", rd_gnt, 0);
    go();
    $display("txn lock burst with pending reads");
    idle(); go();

    // Reset one cycle after a read grant, from a locked request
    rd_req = 1; rd_addr = 14'h1234; wr_lock = 1;
    @(negedge CLK); chk("rs_rgnt", rd_gnt, 1);
    go();
    RSTN = 0; rd_req = 0;
    @(negedge CLK); chk("rs_wgnt_low", wr_gnt, 0); chk("rs_rgnt_low", rd_gnt, 0);
    go();
    RSTN = 1; wr_lock = 0; rd_req = 1; wr_req = 1; rd_addr = 14'h0005; wr_addr = 14'h0006;
    @(negedge CLK);
    chk("rs_no_valid", rd_valid, 0); chk("rs_cen", mem_cen, 1); chk("rs_a", mem_a, 0);
    chk("rs_state_arb", rd_gnt, 1);
    go();
    idle(); go(); go();
    $display("txn reset drops pending read");

    // Randomized traffic including lock bursts and occasional resets
    for (int i = 0; i < 3000; i++) begin
      RSTN    = ($urandom_range(0, 199) != 0);
      wr_req  = ($urandom_range(0, 9) < 5);
      rd_req  = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 29) == 0) wr_lock = ~wr_lock;
      wr_addr = ($urandom_range(0, 15) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
      rd_addr = ($urandom_range(0, 15) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
      wr_data = 16'($urandom);
      go();
    end
    RSTN = 1; idle(); go(); go(); go();
    $display("txn random phase 3000 cycles");

    // Fill the whole memory, then read it back-to-back
    wr_req = 1;
    for (int a = 0; a < DEPTH; a++) begin
      wr_addr = 14'(a);
      wr_data = 16'(a * 3 + 16'h1234);
      go();
    end
    wr_req = 0; rd_req = 1; count_en = 1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 14'(a);
      go();
    end
    rd_req = 0;
    go();
    @(negedge CLK); chk("fill_last_valid", rd_valid, 1); chk("fill_3fff", rd_data, 16'hD231);
    go();
    count_en = 0;
    chk("fill_valid_cnt", vcnt, DEPTH);
    $display("txn fill/readback %0d words, valids %0d", DEPTH, vcnt);
    go(); go();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
